// File: rtl/goertzel_bin_detector.sv
// goertzel_bin_detector
// Collects one Goertzel magnitude per bin per frame (bin 0 first), reports the
// strongest bin of each frame, and debounces threshold hits across frames into
// a stable tone-detect level with a rising-edge event pulse.
// Optional build macro: GOERTZEL_DET_HYST_EN -- when defined, an asserted
// detect is held by frames whose max stays on detect_bin at >= thresh/2.
module goertzel_bin_detector #(
  parameter int MAG_W    = 16,
  parameter int BIN_W    = 5,
  parameter int DEBOUNCE = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clear,
  input  logic [MAG_W-1:0] mag_in,
  input  logic             mag_rdy,
  input  logic [BIN_W-1:0] num_bins,
  input  logic [MAG_W-1:0] thresh,
  output logic             frame_done,
  output logic [BIN_W-1:0] frame_max_bin,
  output logic [MAG_W-1:0] frame_max_mag,
  output logic             detect,
  output logic [BIN_W-1:0] detect_bin,
  output logic             detect_event
);

  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);

  // Frame collection state
  logic [BIN_W-1:0] bin_idx_q, bin_idx_d;
  logic [BIN_W-1:0] frame_len_q, frame_len_d;
  logic [MAG_W-1:0] run_max_q, run_max_d;
  logic [BIN_W-1:0] run_bin_q, run_bin_d;
  // Frame result registers
  logic             frame_done_q, frame_done_d;
  logic [BIN_W-1:0] fmax_bin_q, fmax_bin_d;
  logic [MAG_W-1:0] fmax_mag_q, fmax_mag_d;
  // Debounce state
  logic [3:0]       deb_cnt_q, deb_cnt_d;
  logic [BIN_W-1:0] cand_bin_q, cand_bin_d;
  logic             detect_q, detect_d;
  logic [BIN_W-1:0] detect_bin_q, detect_bin_d;
  logic             event_q, event_d;

  // Combinational helpers
  logic [BIN_W-1:0] len;
  logic             take;
  logic [MAG_W-1:0] new_max;
  logic [BIN_W-1:0] new_bin;
  logic             hit;
  logic             same;
  logic             hold;

  // Next-state logic: frame accumulation, frame close, debounce, clear
  // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    bin_idx_d    = bin_idx_q;
    frame_len_d  = frame_len_q;
    run_max_d    = run_max_q;
    run_bin_d    = run_bin_q;
    frame_done_d = 1'b0;
    fmax_bin_d   = fmax_bin_q;
    fmax_mag_d   = fmax_mag_q;
    deb_cnt_d    = deb_cnt_q;
    cand_bin_d   = cand_bin_q;
    detect_d     = detect_q;
    detect_bin_d = detect_bin_q;
    event_d      = 1'b0;

    // Frame length is sampled at bin 0 and frozen for the rest of the frame.
    len     = (bin_idx_q == '0) ? num_bins : frame_len_q;
    // Bin 0 loads unconditionally; strict > keeps the lower index on ties.
    take    = (bin_idx_q == '0) || (mag_in > run_max_q);
    new_max = take ? mag_in : run_max_q;
    new_bin = take ? bin_idx_q : run_bin_q;

    hit  = (fmax_mag_q >= thresh);
    same = (fmax_bin_q == cand_bin_q);
`ifdef GOERTZEL_DET_HYST_EN
    // A below-threshold frame still holds an asserted detect on the same bin.
    hold = detect_q && (fmax_bin_q == detect_bin_q) &&
           (fmax_mag_q >= (thresh >> 1)) && !hit;
`else
    hold = 1'b0;
`endif

    // A zero-length frame discards the sample and leaves bin_idx at 0.
    if (mag_rdy && (len != '0)) begin
      if (bin_idx_q == '0) frame_len_d = num_bins;
      run_max_d = new_max;
      run_bin_d = new_bin;
      if (bin_idx_q == len - BIN_W'(1)) begin
        bin_idx_d    = '0;
        frame_done_d = 1'b1;
        fmax_bin_d   = new_bin;
        fmax_mag_d   = new_max;
      end else begin
        bin_idx_d = bin_idx_q + BIN_W'(1);
      end
    end

    // Debounce runs on the registered frame result in the frame_done cycle.
    if (frame_done_q && !hold) begin
      if (!hit) begin
        deb_cnt_d = '0;
        detect_d  = 1'b0;
      end else if ((deb_cnt_q == '0) || same) begin
        deb_cnt_d  = (deb_cnt_q >= DEB_MAX) ? DEB_MAX : deb_cnt_q + 4'd1;
        cand_bin_d = fmax_bin_q;
      end else begin
        deb_cnt_d  = 4'd1;
        cand_bin_d = fmax_bin_q;
        detect_d   = 1'b0;
      end
      if (deb_cnt_d == DEB_MAX) begin
        detect_d     = 1'b1;
        detect_bin_d = cand_bin_d;
      end
    end
    event_d = detect_d && !detect_q;

    // Clear wins over everything, including a coincident mag_rdy.
    if (clear) begin
      bin_idx_d    = '0;
      frame_len_d  = '0;
      run_max_d    = '0;
      run_bin_d    = '0;
      frame_done_d = 1'b0;
      fmax_bin_d   = '0;
      fmax_mag_d   = '0;
      deb_cnt_d    = '0;
      cand_bin_d   = '0;
      detect_d     = 1'b0;
      detect_bin_d = '0;
      event_d      = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_idx_q    <= '0;
      frame_len_q  <= '0;
      run_max_q    <= '0;
      run_bin_q    <= '0;
      frame_done_q <= 1'b0;
      fmax_bin_q   <= '0;
      fmax_mag_q   <= '0;
      deb_cnt_q    <= '0;
      cand_bin_q   <= '0;
      detect_q     <= 1'b0;
      detect_bin_q <= '0;
      event_q      <= 1'b0;
    end else begin
      bin_idx_q    <= bin_idx_d;
      frame_len_q  <= frame_len_d;
      run_max_q    <= run_max_d;
      run_bin_q    <= run_bin_d;
      frame_done_q <= frame_done_d;
      fmax_bin_q   <= fmax_bin_d;
      fmax_mag_q   <= fmax_mag_d;
      deb_cnt_q    <= deb_cnt_d;
      cand_bin_q   <= cand_bin_d;
      detect_q     <= detect_d;
      detect_bin_q <= detect_bin_d;
      event_q      <= event_d;
    end
  end

  assign frame_done    = frame_done_q;
  assign frame_max_bin = fmax_bin_q;
  assign frame_max_mag = fmax_mag_q;
  assign detect        = detect_q;
  assign detect_bin    = detect_bin_q;
  assign detect_event  = event_q;

endmodule

// File: tb/tb_goertzel_bin_detector.sv
// Testbench for goertzel_bin_detector: directed scenarios plus randomized
// frames, checked against a frame-level reference model.
module tb_goertzel_bin_detector;

  localparam int MAG_W    = 16;
  localparam int BIN_W    = 5;
  localparam int DEBOUNCE = 3;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             clear;
  logic [MAG_W-1:0] mag_in;
  logic             mag_rdy;
  logic [BIN_W-1:0] num_bins;
  logic [MAG_W-1:0] thresh;
  logic             frame_done;
  logic [BIN_W-1:0] frame_max_bin;
  logic [MAG_W-1:0] frame_max_mag;
  logic             detect;
  logic [BIN_W-1:0] detect_bin;
  logic             detect_event;

  goertzel_bin_detector #(
    .MAG_W(MAG_W), .BIN_W(BIN_W), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(clear),
    .mag_in(mag_in), .mag_rdy(mag_rdy), .num_bins(num_bins), .thresh(thresh),
    .frame_done(frame_done), .frame_max_bin(frame_max_bin),
    .frame_max_mag(frame_max_mag), .detect(detect), .detect_bin(detect_bin),
    .detect_event(detect_event)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests;
  int n_fail;

  // Current frame magnitudes (first n entries used)
  int fr[16];

  // Frame-level debounce model
  int m_deb, m_cand, m_det, m_det_bin;
  bit pend_event;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic strobe(input int v);
    mag_in  = 16'(v);
    mag_rdy = 1'b1;
    tick();
    mag_rdy = 1'b0;
  endtask

  task automatic set4(input int a, input int b, input int c, input int d);
    fr[0] = a; fr[1] = b; fr[2] = c; fr[3] = d;
  endtask

  task automatic model_reset();
    m_deb = 0; m_cand = 0; m_det = 0; m_det_bin = 0; pend_event = 1'b0;
  endtask

  // Apply one finished frame (max bin/mag) to the debounce rules.
  task automatic model_frame(input int bin, input int mag, input int th, output bit ev);
    int was;
    bit hit;
    was = m_det;
    hit = (mag >= th);
    ev  = 1'b0;
`ifdef GOERTZEL_DET_HYST_EN
    if (m_det == 1 && bin == m_det_bin && mag >= th / 2 && !hit) return;
`endif
    if (!hit) begin
      m_deb = 0;
      m_det = 0;
    end else if (m_deb == 0 || bin == m_cand) begin
      m_deb  = (m_deb + 1 > DEBOUNCE) ? DEBOUNCE : m_deb + 1;
      m_cand = bin;
    end else begin
      m_deb  = 1;
      m_cand = bin;
      m_det  = 0;
    end
    if (m_deb == DEBOUNCE) begin
      m_det     = 1;
      m_det_bin = m_cand;
    end
    ev = (m_det == 1) && (was == 0);
  endtask

  task automatic check_all_zero(input string tag);
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s frame_done got %0b exp 0", tag, frame_done); end
    n_tests++; if (frame_max_bin !== '0) begin n_fail++; $display("FAIL %s frame_max_bin got %0d exp 0", tag, frame_max_bin); end
    n_tests++; if (frame_max_mag !== '0) begin n_fail++; $display("FAIL %s frame_max_mag got %0d exp 0", tag, frame_max_mag); end
    n_tests++; if (detect !== 1'b0) begin n_fail++; $display("FAIL %s detect got %0b exp 0", tag, detect); end
    n_tests++; if (detect_bin !== '0) begin n_fail++; $display("FAIL %s detect_bin got %0d exp 0", tag, detect_bin); end
    n_tests++; if (detect_event !== 1'b0) begin n_fail++; $display("FAIL %s detect_event got %0b exp 0", tag, detect_event); end
  endtask

  // Called in the frame_done cycle: check the frame result, update the model.
  task automatic finish_frame(input int n, input string tag);
    int eb, em;
    eb = 0; em = fr[0];
    for (int i = 1; i < n; i++) if (fr[i] > em) begin em = fr[i]; eb = i; end
    n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL %s frame_done got %0b exp 1", tag, frame_done); end
    n_tests++; if (frame_max_bin !== 5'(eb)) begin n_fail++; $display("FAIL %s frame_max_bin got %0d exp %0d", tag, frame_max_bin, eb); end
    n_tests++; if (frame_max_mag !== 16'(em)) begin n_fail++; $display("FAIL %s frame_max_mag got %0d exp %0d", tag, frame_max_mag, em); end
    model_frame(eb, em, int'(thresh), pend_event);
  endtask

  // Called the cycle after frame_done: check debounce outcome.
  task automatic check_detect(input string tag);
    n_tests++; if (detect !== m_det[0]) begin n_fail++; $display("FAIL %s detect got %0b exp %0d", tag, detect, m_det); end
    if (m_det == 1) begin
      n_tests++; if (detect_bin !== 5'(m_det_bin)) begin n_fail++; $display("FAIL %s detect_bin got %0d exp %0d", tag, detect_bin, m_det_bin); end
    end
    n_tests++; if (detect_event !== pend_event) begin n_fail++; $display("FAIL %s detect_event got %0b exp %0b", tag, detect_event, pend_event); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s frame_done not one-cycle got %0b", tag, frame_done); end
  endtask

  task automatic play_frame(input int n, input int start, input bit gaps,
                            input bit tail, input bit scramble, input string tag);
    for (int i = start; i < n; i++) begin
      strobe(fr[i]);
      if (scramble && i == start) num_bins = 5'($urandom_range(0, 31));
      if (i < n - 1) begin
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s early frame_done at bin %0d", tag, i); end
        if (gaps) idle($urandom_range(0, 2));
      end
    end
    finish_frame(n, tag);
    if (tail) begin
      tick();
      check_detect(tag);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    idle(3);
    check_all_zero("reset_held");
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick();
    check_all_zero("reset_released");
    model_reset();
  endtask

  task automatic test_detect();
    num_bins = 5'd4;
    thresh   = 16'd1000;
    for (int k = 0; k < 3; k++) begin
      set4(400, 32000, 162, 2);
      play_frame(4, 0, 1'b0, 1'b1, 1'b0, "detect");
    end
    n_tests++; if (detect !== 1'b1 || detect_bin !== 5'd1) begin n_fail++; $display("FAIL detect_after_3 got det=%0b bin=%0d exp det=1 bin=1", detect, detect_bin); end
  endtask

  task automatic test_release();
    thresh = 16'd1000;
    set4(400, 700, 162, 2);
    play_frame(4, 0, 1'b0, 1'b1, 1'b0, "release_700");
    set4(100, 400, 162, 2);
    play_frame(4, 0, 1'b0, 1'b1, 1'b0, "release_400");
    n_tests++; if (detect !== 1'b0) begin n_fail++; $display("FAIL release_final got %0b exp 0", detect); end
  endtask

  task automatic test_tie();
    thresh = 16'd100;
    set4(500, 500, 10, 10);
    play_frame(4, 0, 1'b1, 1'b1, 1'b0, "tie_low");
    for (int k = 0; k < 3; k++) begin
      set4(10, 600, 600, 10);
      play_frame(4, 0, 1'b1, 1'b1, 1'b0, "tie_restart");
    end
  endtask

  task automatic test_back_to_back();
    thresh = 16'd1000;
    set4(1, 2, 3, 40000);
    play_frame(4, 0, 1'b0, 1'b0, 1'b0, "b2b_a");
    set4(50000, 7, 8, 9);
    strobe(fr[0]);             // bin 0 of next frame in the frame_done cycle
    check_detect("b2b_a");
    play_frame(4, 1, 1'b0, 1'b1, 1'b0, "b2b_b");
  endtask

  task automatic test_clear();
    thresh = 16'd1000;
    for (int k = 0; k < 3; k++) begin
      set4(400, 32000, 162, 2);
      play_frame(4, 0, 1'b0, 1'b1, 1'b0, "clear_prime");
    end
    strobe(100);
    strobe(200);
    clear = 1'b1; tick(); clear = 1'b0;
    model_reset();
    check_all_zero("clear_mid");
    strobe(60000);
    clear = 1'b1; mag_in = 16'd60001; mag_rdy = 1'b1;
    tick();
    clear = 1'b0; mag_rdy = 1'b0;
    check_all_zero("clear_coincident");
    set4(5, 6, 7, 8);
    play_frame(4, 0, 1'b0, 1'b1, 1'b0, "clear_after");
  endtask

  task automatic test_zero_bins();
    num_bins = 5'd0;
    for (int k = 0; k < 5; k++) begin
      strobe(30000 + k);
      n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL zero_bins frame_done got 1 at strobe %0d", k); end
    end
    tick();
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL zero_bins trailing frame_done got 1"); end
    num_bins = 5'd4;
    set4(1, 2, 30, 4);
    play_frame(4, 0, 1'b0, 1'b1, 1'b0, "zero_then_4");
  endtask

  task automatic test_async_reset();
    thresh = 16'd1000;
    set4(10, 20000, 5, 5);
    play_frame(4, 0, 1'b0, 1'b1, 1'b0, "arst_pre");
    strobe(123);
    strobe(456);
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("arst_immediate");
    @(negedge sys_clk) sys_rst_n = 1'b1;
    model_reset();
    set4(3, 1, 4, 1);
    play_frame(4, 0, 1'b0, 1'b1, 1'b0, "arst_post");
  endtask

  task automatic test_random();
    int n, tone;
    n = 4; tone = 0;
    for (int f = 0; f < 60; f++) begin
      if (f == 0 || $urandom_range(0, 7) == 0) n = $urandom_range(1, 8);
      if (tone >= n || $urandom_range(0, 4) == 0) tone = $urandom_range(0, n - 1);
      if (f % 10 == 0) thresh = 16'($urandom_range(2000, 20000));
      for (int j = 0; j < n; j++) begin
        fr[j] = $urandom_range(0, int'(thresh) - 1);
        if (j > 0 && $urandom_range(0, 5) == 0) fr[j] = fr[j-1];
      end
      if ($urandom_range(0, 3) != 0) fr[tone] = $urandom_range(int'(thresh) / 2, 65535);
      num_bins = 5'(n);
      play_frame(n, 0, 1'b1, 1'b1, 1'b1, "random");
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    clear    = 1'b0;
    mag_rdy  = 1'b0;
    mag_in   = '0;
    num_bins = 5'd4;
    thresh   = 16'd1000;
    sys_rst_n = 1'b0;
    model_reset();
    test_reset();
    test_detect();
    test_release();
    test_tie();
    test_back_to_back();
    test_clear();
    test_zero_bins();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
